// File: rtl/rl_pkg.sv
// rl_pkg: definitions shared by the grid-world step sequencer and the policy unit.
//   STATE_W / REWARD_W / ACT_W : grid state, reward and action widths
//   act_t                      : action encodings (up/down/left/right)
//   seq_state_t                : step sequencer FSM states
//   sat_add                    : signed saturating add on reward-width values
package rl_pkg;

    localparam int STATE_W  = 8;
    localparam int REWARD_W = 16;
    localparam int ACT_W    = 2;

    typedef enum logic [ACT_W-1:0] {
        ACT_UP    = 2'd0,
        ACT_DOWN  = 2'd1,
        ACT_LEFT  = 2'd2,
        ACT_RIGHT = 2'd3
    } act_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACT,
        S_EVAL,
        S_SAMPLE,
        S_EMIT,
        S_EP_RST
    } seq_state_t;

    // One extra bit catches overflow; a sign disagreement between the two top
    // bits means the true sum left the representable range.
    function automatic logic signed [REWARD_W-1:0] sat_add(
        input logic signed [REWARD_W-1:0] a,
        input logic signed [REWARD_W-1:0] b
    );
        logic signed [REWARD_W:0] s;
        s = {a[REWARD_W-1], a} + {b[REWARD_W-1], b};
        if (s[REWARD_W] != s[REWARD_W-1]) begin
            return s[REWARD_W] ? {1'b1, {(REWARD_W-1){1'b0}}}
                               : {1'b0, {(REWARD_W-1){1'b1}}};
        end
        return s[REWARD_W-1:0];
    endfunction

endpackage

// File: rtl/rl_grid_step.sv
// rl_grid_step: combinational grid-world move on a 16x16 grid, state = {row, col}.
// A move that would leave the grid clamps (state unchanged).
//   state      in  8 : current state
//   act        in  2 : action (up/down/left/right)
//   next_state out 8 : resulting state
module rl_grid_step
    import rl_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [ACT_W-1:0]   act,
    output logic [STATE_W-1:0] next_state
);

    logic [3:0] row;
    logic [3:0] col;

    always_comb begin
        row        = state[7:4];
        col        = state[3:0];
        next_state = state;
        case (act)
            ACT_UP:    if (row != 4'd0)  next_state = {row - 4'd1, col};
            ACT_DOWN:  if (row != 4'hF)  next_state = {row + 4'd1, col};
            ACT_LEFT:  if (col != 4'd0)  next_state = {row, col - 4'd1};
            ACT_RIGHT: if (col != 4'hF)  next_state = {row, col + 4'd1};
            default:   next_state = state;
        endcase
    end

endmodule

// File: rtl/rl_step_sequencer.sv
// rl_step_sequencer: takes actions from the policy, drives the reward module with
// current/next state, captures its reward and emits one (s, a, r, s') record per
// step. Counts steps and episodes and pulses the reward module's state reset at
// every episode boundary.
// Optional episode reward accumulator: define RL_SEQ_EP_REWARD_EN.
//   clk, rst (sync, active high)
//   start, start_state       : run start (IDLE only) / initial state of every episode
//   act_valid/act_ready/act  : action handshake from policy
//   cur_state, nxt_state     : to reward module
//   state_rst                : reward module state reset, one cycle per episode end
//   reward_in                : reward from reward module
//   tr_valid/tr_ready, tr_state/tr_action/tr_reward/tr_next/tr_last : transition out
//   step_cnt, ep_cnt         : steps in current episode, completed episodes
//   busy, done               : run status
//   ep_reward                : saturating episode reward sum (0 when not built)
module rl_step_sequencer
    import rl_pkg::*;
#(
    parameter int                  MAX_STEPS  = 64,
    parameter int                  N_EPISODES = 256,
    parameter logic [STATE_W-1:0]  GOAL_STATE = 8'hFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [STATE_W-1:0]         start_state,
    input  logic                       act_valid,
    output logic                       act_ready,
    input  logic [ACT_W-1:0]           act,
    output logic [STATE_W-1:0]         cur_state,
    output logic [STATE_W-1:0]         nxt_state,
    output logic                       state_rst,
    input  logic signed [REWARD_W-1:0] reward_in,
    output logic                       tr_valid,
    input  logic                       tr_ready,
    output logic [STATE_W-1:0]         tr_state,
    output logic [ACT_W-1:0]           tr_action,
    output logic signed [REWARD_W-1:0] tr_reward,
    output logic [STATE_W-1:0]         tr_next,
    output logic                       tr_last,
    output logic [7:0]                 step_cnt,
    output logic [15:0]                ep_cnt,
    output logic                       busy,
    output logic                       done,
    output logic signed [REWARD_W-1:0] ep_reward
);

    localparam logic [8:0]  MAX_STEPS_L  = 9'(MAX_STEPS);
    localparam logic [16:0] N_EPISODES_L = 17'(N_EPISODES);

    seq_state_t         state;
    logic [ACT_W-1:0]   act_q;
    logic [STATE_W-1:0] step_next;
    logic [8:0]         step_inc;
    logic [16:0]        ep_inc;

    rl_grid_step u_grid_step (
        .state      (cur_state),
        .act        (act),
        .next_state (step_next)
    );

    assign step_inc = {1'b0, step_cnt} + 9'd1;
    assign ep_inc   = {1'b0, ep_cnt} + 17'd1;

    // nxt_state is only advanced ahead of cur_state between action accept and
    // the transition handshake; every other cur_state update also loads nxt_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            act_q     <= '0;
            act_ready <= 1'b0;
            cur_state <= '0;
            nxt_state <= '0;
            state_rst <= 1'b0;
            tr_valid  <= 1'b0;
            tr_state  <= '0;
            tr_action <= '0;
            tr_reward <= '0;
            tr_next   <= '0;
            tr_last   <= 1'b0;
            step_cnt  <= '0;
            ep_cnt    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_rst <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_state <= start_state;
                        nxt_state <= start_state;
                        step_cnt  <= '0;
                        ep_cnt    <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        act_ready <= 1'b1;
                        state     <= S_WAIT_ACT;
                    end
                end
                S_WAIT_ACT: begin
                    if (act_valid) begin
                        act_q     <= act;
                        nxt_state <= step_next;
                        act_ready <= 1'b0;
                        state     <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    tr_state  <= cur_state;
                    tr_action <= act_q;
                    tr_reward <= reward_in;
                    tr_next   <= nxt_state;
                    tr_last   <= (nxt_state == GOAL_STATE) || (step_inc == MAX_STEPS_L);
                    tr_valid  <= 1'b1;
                    state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (tr_ready) begin
                        tr_valid  <= 1'b0;
                        cur_state <= nxt_state;
                        step_cnt  <= step_inc[7:0];
                        if (tr_last) begin
                            state_rst <= 1'b1;
                            state     <= S_EP_RST;
                        end else begin
                            act_ready <= 1'b1;
                            state     <= S_WAIT_ACT;
                        end
                    end
                end
                S_EP_RST: begin
                    cur_state <= start_state;
                    nxt_state <= start_state;
                    step_cnt  <= '0;
                    ep_cnt    <= ep_inc[15:0];
                    if (ep_inc == N_EPISODES_L) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        act_ready <= 1'b1;
                        state     <= S_WAIT_ACT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RL_SEQ_EP_REWARD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ep_reward <= '0;
        end else if ((state == S_IDLE && start) || state == S_EP_RST) begin
            ep_reward <= '0;
        end else if (state == S_EMIT && tr_ready) begin
            ep_reward <= sat_add(ep_reward, tr_reward);
        end
    end
`else
    assign ep_reward = '0;
`endif

endmodule

// File: tb/tb_rl_step_sequencer.sv
// Self-checking bench for rl_step_sequencer (MAX_STEPS=2, N_EPISODES=2, goal 8'hFF).
// A reward-module stub drives reward_in from cur_state/nxt_state; expectations come
// from a grid/episode model written with plain integer arithmetic.
module tb_rl_step_sequencer;

    localparam int         MAX_STEPS  = 2;
    localparam int         N_EPISODES = 2;
    localparam logic [7:0] GOAL       = 8'hFF;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         start_state;
    logic               act_valid;
    logic               act_ready;
    logic [1:0]         act;
    logic [7:0]         cur_state;
    logic [7:0]         nxt_state;
    logic               state_rst;
    logic signed [15:0] reward_in;
    logic               tr_valid;
    logic               tr_ready;
    logic [7:0]         tr_state;
    logic [1:0]         tr_action;
    logic signed [15:0] tr_reward;
    logic [7:0]         tr_next;
    logic               tr_last;
    logic [7:0]         step_cnt;
    logic [15:0]        ep_cnt;
    logic               busy;
    logic               done;
    logic signed [15:0] ep_reward;

    // reward module stub
    logic               stub_force = 1'b0;
    logic signed [15:0] stub_val = '0;
    logic [7:0]         salt = '0;
    assign reward_in = stub_force ? stub_val : $signed({nxt_state ^ salt, cur_state});

    rl_step_sequencer #(
        .MAX_STEPS  (MAX_STEPS),
        .N_EPISODES (N_EPISODES),
        .GOAL_STATE (GOAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_state (start_state),
        .act_valid   (act_valid),
        .act_ready   (act_ready),
        .act         (act),
        .cur_state   (cur_state),
        .nxt_state   (nxt_state),
        .state_rst   (state_rst),
        .reward_in   (reward_in),
        .tr_valid    (tr_valid),
        .tr_ready    (tr_ready),
        .tr_state    (tr_state),
        .tr_action   (tr_action),
        .tr_reward   (tr_reward),
        .tr_next     (tr_next),
        .tr_last     (tr_last),
        .step_cnt    (step_cnt),
        .ep_cnt      (ep_cnt),
        .busy        (busy),
        .done        (done),
        .ep_reward   (ep_reward)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    int m_cur, m_step, m_ep, m_epr;
    bit m_done;

    typedef struct {
        int                 lat;
        logic [7:0]         ev_nxt;
        logic [7:0]         st;
        logic [1:0]         ac;
        logic signed [15:0] rw;
        logic [7:0]         nx;
        logic               last;
        logic               srst;
        logic               srst2;
        logic signed [15:0] epr;
    } obs_t;

    typedef struct {
        logic [7:0]         st;
        logic [7:0]         nx;
        logic signed [15:0] rw;
        logic               last;
        logic signed [15:0] epr;
        logic [7:0]         cur_after;
    } exp_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_step(int s, int a);
        int r = s / 16;
        int c = s % 16;
        case (a)
            0: if (r > 0)  r = r - 1;
            1: if (r < 15) r = r + 1;
            2: if (c > 0)  c = c - 1;
            default: if (c < 15) c = c + 1;
        endcase
        return r * 16 + c;
    endfunction

    function automatic logic signed [15:0] model_reward(int cur, int nxt);
        int v;
        if (stub_force) return stub_val;
        v = ((nxt ^ int'(salt)) % 256) * 256 + cur;
        if (v >= 32768) v = v - 65536;
        return 16'(v);
    endfunction

    function automatic int sat(int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_apply(input int a, output exp_t e);
        int nxt;
        e.st = 8'(m_cur);
        nxt  = model_step(m_cur, a);
        e.nx = 8'(nxt);
        e.rw = model_reward(m_cur, nxt);
        m_step = m_step + 1;
        e.last = (nxt == int'(GOAL)) || (m_step == MAX_STEPS);
`ifdef RL_SEQ_EP_REWARD_EN
        m_epr = sat(m_epr + int'(e.rw));
        e.epr = 16'(m_epr);
`else
        e.epr = '0;
`endif
        if (e.last) begin
            m_cur  = int'(start_state);
            m_step = 0;
            m_ep   = m_ep + 1;
            m_epr  = 0;
            if (m_ep == N_EPISODES) m_done = 1'b1;
        end else begin
            m_cur = nxt;
        end
        e.cur_after = 8'(m_cur);
    endtask

    task automatic do_start(input logic [7:0] s);
        start_state = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_cur = int'(s); m_step = 0; m_ep = 0; m_epr = 0; m_done = 1'b0;
    endtask

    // Drives one action with tr_ready high and records what the DUT showed.
    task automatic run_step(input logic [1:0] a, output obs_t o);
        int n;
        tr_ready  = 1'b1;
        act       = a;
        act_valid = 1'b1;
        tick();
        act_valid = 1'b0;
        o.ev_nxt = nxt_state;
        n = 1;
        while (!tr_valid && n < 20) begin
            tick();
            n++;
        end
        o.lat  = n;
        o.st   = tr_state;
        o.ac   = tr_action;
        o.rw   = tr_reward;
        o.nx   = tr_next;
        o.last = tr_last;
        tick();
        o.srst = state_rst;
        o.epr  = ep_reward;
        tick();
        o.srst2 = state_rst;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        start_state = 8'($urandom);
        act_valid = 1'b1;
        act = 2'($urandom);
        tr_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0; start = 1'b0; act_valid = 1'b0; tr_ready = 1'b0;
        total++;
        if ({act_ready, tr_valid, tr_state, tr_action, tr_reward, tr_next, tr_last,
             cur_state, nxt_state, state_rst, step_cnt, ep_cnt, busy, done, ep_reward} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: cur=%h nxt=%h busy=%b ready=%b valid=%b step=%0d ep=%0d done=%b, required all 0",
                     cur_state, nxt_state, busy, act_ready, tr_valid, step_cnt, ep_cnt, done);
        end
        tick();
        total++;
        if ({busy, act_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle: busy=%b act_ready=%b, required 0 0", busy, act_ready);
        end
    endtask

    task automatic test_first_step();
        obs_t o;
        exp_t e;
        logic [1:0] a;
        salt = 8'($urandom);
        do_start(8'h00);
        total++;
        if ({busy, act_ready, cur_state, nxt_state, step_cnt, done} !== {1'b1, 1'b1, 8'h00, 8'h00, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL start_load: busy=%b ready=%b cur=%h nxt=%h step=%0d done=%b", busy, act_ready,
                     cur_state, nxt_state, step_cnt, done);
        end
        model_apply(3, e);
        run_step(2'd3, o);
        total++;
        if (o.ev_nxt !== 8'h01) begin
            bad++; $display("FAIL eval_nxt: got %h, required 01", o.ev_nxt);
        end
        total++;
        if (o.lat !== 3) begin
            bad++; $display("FAIL valid_latency: got %0d cycles, required 3", o.lat);
        end
        total++;
        if ({o.st, o.ac, o.rw, o.nx, o.last} !== {8'h00, 2'd3, e.rw, 8'h01, 1'b0}) begin
            bad++;
            $display("FAIL first_payload: s=%h a=%0d r=%0d n=%h last=%b, required s=00 a=3 r=%0d n=01 last=0",
                     o.st, o.ac, o.rw, o.nx, o.last, e.rw);
        end
        total++;
        if ({o.srst, cur_state, step_cnt, act_ready} !== {1'b0, 8'h01, 8'd1, 1'b1}) begin
            bad++;
            $display("FAIL after_first: srst=%b cur=%h step=%0d ready=%b, required 0 01 1 1",
                     o.srst, cur_state, step_cnt, act_ready);
        end
        a = 2'($urandom);
        model_apply(int'(a), e);
        run_step(a, o);
        total++;
        if ({o.last, o.srst, o.srst2} !== 3'b110) begin
            bad++;
            $display("FAIL limit_last: last=%b srst=%b srst_next=%b, required 1 1 0", o.last, o.srst, o.srst2);
        end
        total++;
        if ({ep_cnt, cur_state, nxt_state, step_cnt, done, busy} !== {16'd1, 8'h00, 8'h00, 8'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL ep_boundary: ep=%0d cur=%h nxt=%h step=%0d done=%b busy=%b, required 1 00 00 0 0 1",
                     ep_cnt, cur_state, nxt_state, step_cnt, done, busy);
        end
    endtask

    task automatic test_clamp_and_ignore();
        obs_t o;
        exp_t e;
        logic [1:0] a;
        start_state = 8'h77;
        start = 1'b1;
        tick();
        start = 1'b0;
        start_state = 8'h00;
        total++;
        if ({cur_state, step_cnt, ep_cnt, act_ready} !== {8'h00, 8'd0, 16'd1, 1'b1}) begin
            bad++;
            $display("FAIL start_ignored: cur=%h step=%0d ep=%0d ready=%b, required 00 0 1 1",
                     cur_state, step_cnt, ep_cnt, act_ready);
        end
        model_apply(0, e);
        run_step(2'd0, o);
        total++;
        if ({o.ev_nxt, o.st, o.nx, o.last} !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL clamp_up: eval_nxt=%h s=%h next=%h last=%b, required 00 00 00 0", o.ev_nxt, o.st, o.nx, o.last);
        end
        a = 2'($urandom);
        model_apply(int'(a), e);
        run_step(a, o);
        total++;
        if ({done, ep_cnt, busy, act_ready} !== {1'b1, 16'd2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL run_done: done=%b ep=%0d busy=%b ready=%b, required 1 2 0 0", done, ep_cnt, busy, act_ready);
        end
        act_valid = 1'b1;
        act = 2'd3;
        tick(); tick(); tick();
        act_valid = 1'b0;
        total++;
        if ({done, busy, tr_valid, act_ready, nxt_state} !== {1'b1, 1'b0, 1'b0, 1'b0, cur_state}) begin
            bad++;
            $display("FAIL idle_hold: done=%b busy=%b valid=%b ready=%b nxt=%h cur=%h, required 1 0 0 0 nxt==cur",
                     done, busy, tr_valid, act_ready, nxt_state, cur_state);
        end
    endtask

    task automatic test_hold();
        obs_t o;
        exp_t e;
        logic [1:0] a;
        logic [7:0] s;
        logic [34:0] snap;
        int n;
        s = 8'($urandom);
        a = 2'($urandom);
        if (model_step(int'(s), int'(a)) == int'(GOAL)) s = 8'h00;
        salt = 8'($urandom);
        do_start(s);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL done_cleared: got %b, required 0", done);
        end
        model_apply(int'(a), e);
        tr_ready = 1'b0;
        act = a;
        act_valid = 1'b1;
        tick();
        act_valid = 1'b0;
        n = 0;
        while (!tr_valid && n < 20) begin
            tick();
            n++;
        end
        snap = {tr_state, tr_action, tr_reward, tr_next, tr_last};
        total++;
        if ({tr_valid, snap} !== {1'b1, e.st, a, e.rw, e.nx, 1'b0}) begin
            bad++;
            $display("FAIL hold_payload: valid=%b s=%h a=%0d r=%0d n=%h, required 1 %h %0d %0d %h",
                     tr_valid, tr_state, tr_action, tr_reward, tr_next, e.st, a, e.rw, e.nx);
        end
        act_valid = 1'b1;
        act = ~a;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({tr_valid, act_ready, step_cnt, tr_state, tr_action, tr_reward, tr_next, tr_last}
                !== {1'b1, 1'b0, 8'd0, snap}) begin
                bad++;
                $display("FAIL hold_stable[%0d]: valid=%b ready=%b step=%0d payload=%h, required 1 0 0 %h",
                         i, tr_valid, act_ready, step_cnt,
                         {tr_state, tr_action, tr_reward, tr_next, tr_last}, snap);
            end
        end
        act_valid = 1'b0;
        tr_ready = 1'b1;
        tick();
        tr_ready = 1'b0;
        total++;
        if ({tr_valid, step_cnt, cur_state} !== {1'b0, 8'd1, e.nx}) begin
            bad++;
            $display("FAIL hold_release: valid=%b step=%0d cur=%h, required 0 1 %h", tr_valid, step_cnt, cur_state, e.nx);
        end
        tick();
        tick();
        total++;
        if ({tr_valid, step_cnt, act_ready} !== {1'b0, 8'd1, 1'b1}) begin
            bad++;
            $display("FAIL single_accept: valid=%b step=%0d ready=%b, required 0 1 1", tr_valid, step_cnt, act_ready);
        end
        a = 2'($urandom);
        model_apply(int'(a), e);
        run_step(a, o);
        total++;
        if ({o.last, ep_cnt, cur_state} !== {1'b1, 16'd1, s}) begin
            bad++;
            $display("FAIL hold_ep_end: last=%b ep=%0d cur=%h, required 1 1 %h", o.last, ep_cnt, cur_state, s);
        end
    endtask

    task automatic test_rst_mid();
        obs_t o;
        exp_t e;
        logic [1:0] a;
        int n;
        tr_ready = 1'b0;
        act = 2'($urandom);
        act_valid = 1'b1;
        tick();
        act_valid = 1'b0;
        n = 0;
        while (!tr_valid && n < 20) begin
            tick();
            n++;
        end
        tick();
        rst = 1'b1;
        tr_ready = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({act_ready, tr_valid, tr_state, tr_action, tr_reward, tr_next, tr_last,
             cur_state, nxt_state, state_rst, step_cnt, ep_cnt, busy, done, ep_reward} !== '0) begin
            bad++;
            $display("FAIL rst_mid: valid=%b busy=%b cur=%h step=%0d ep=%0d, required all 0",
                     tr_valid, busy, cur_state, step_cnt, ep_cnt);
        end
        tick();
        total++;
        if ({tr_valid, busy, state_rst} !== 3'b000) begin
            bad++;
            $display("FAIL rst_no_emit: valid=%b busy=%b srst=%b, required 0 0 0", tr_valid, busy, state_rst);
        end
        tr_ready = 1'b0;
        salt = 8'($urandom);
        do_start(8'($urandom));
        n = 0;
        while (!m_done && n < 10) begin
            a = 2'($urandom);
            model_apply(int'(a), e);
            run_step(a, o);
            n++;
        end
        tick(); tick(); tick();
        total++;
        if ({done, ep_cnt, busy} !== {1'b1, 16'd2, 1'b0}) begin
            bad++;
            $display("FAIL rerun_done: done=%b ep=%0d busy=%b, required 1 2 0", done, ep_cnt, busy);
        end
    endtask

    task automatic test_goal();
        obs_t o;
        exp_t e;
        logic [1:0] acts [4] = '{2'd3, 2'd3, 2'd1, 2'd3};
        logic [7:0] nexts [4] = '{8'hFE, 8'hFF, 8'hFD, 8'hFE};
        logic       lasts [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_start(8'hFD);
        for (int i = 0; i < 4; i++) begin
            model_apply(int'(acts[i]), e);
            run_step(acts[i], o);
            total++;
            if ({o.nx, o.last, o.srst, o.srst2} !== {nexts[i], lasts[i], lasts[i], 1'b0}) begin
                bad++;
                $display("FAIL goal_seq[%0d]: next=%h last=%b srst=%b srst_next=%b, required %h %b %b 0",
                         i, o.nx, o.last, o.srst, o.srst2, nexts[i], lasts[i], lasts[i]);
            end
            if (i == 1) begin
                total++;
                if ({ep_cnt, cur_state, step_cnt} !== {16'd1, 8'hFD, 8'd0}) begin
                    bad++;
                    $display("FAIL goal_boundary: ep=%0d cur=%h step=%0d, required 1 FD 0", ep_cnt, cur_state, step_cnt);
                end
            end
        end
        do_start(8'hFE);
        start_state = GOAL;
        model_apply(3, e);
        run_step(2'd3, o);
        total++;
        if ({o.nx, o.last, ep_cnt, cur_state} !== {8'hFF, 1'b1, 16'd1, 8'hFF}) begin
            bad++;
            $display("FAIL goal_only: next=%h last=%b ep=%0d cur=%h, required FF 1 1 FF", o.nx, o.last, ep_cnt, cur_state);
        end
        model_apply(0, e);
        run_step(2'd0, o);
        total++;
        if ({o.st, o.nx, o.last, step_cnt} !== {8'hFF, 8'hEF, 1'b0, 8'd1}) begin
            bad++;
            $display("FAIL start_at_goal: s=%h next=%h last=%b step=%0d, required FF EF 0 1", o.st, o.nx, o.last, step_cnt);
        end
        model_apply(1, e);
        run_step(2'd1, o);
        total++;
        if ({o.last, done, ep_cnt} !== {1'b1, 1'b1, 16'd2}) begin
            bad++;
            $display("FAIL goal_done: last=%b done=%b ep=%0d, required 1 1 2", o.last, done, ep_cnt);
        end
    endtask

    task automatic test_ep_reward();
        obs_t o;
        exp_t e;
        logic signed [15:0] sat_hi, sat_lo, neg;
`ifdef RL_SEQ_EP_REWARD_EN
        sat_hi = 16'sd32767; sat_lo = -16'sd32768; neg = -16'sd20000;
`else
        sat_hi = '0; sat_lo = '0; neg = '0;
`endif
        do_start(8'h00);
        stub_force = 1'b1;
        stub_val = 16'sd20000;
        model_apply(3, e);
        run_step(2'd3, o);
        model_apply(1, e);
        run_step(2'd1, o);
        total++;
        if (o.epr !== sat_hi) begin
            bad++; $display("FAIL epr_sat_hi: got %0d, required %0d", o.epr, sat_hi);
        end
        stub_val = -16'sd20000;
        model_apply(3, e);
        run_step(2'd3, o);
        total++;
        if (o.epr !== neg) begin
            bad++; $display("FAIL epr_cleared: got %0d, required %0d", o.epr, neg);
        end
        model_apply(1, e);
        run_step(2'd1, o);
        total++;
        if (o.epr !== sat_lo) begin
            bad++; $display("FAIL epr_sat_lo: got %0d, required %0d", o.epr, sat_lo);
        end
        stub_force = 1'b0;
    endtask

    task automatic test_random_runs();
        obs_t o;
        exp_t e;
        logic [1:0] a;
        int n;
        for (int run = 0; run < 6; run++) begin
            salt = 8'($urandom);
            do_start(8'($urandom));
            n = 0;
            while (!m_done && n < 10) begin
                if ($urandom_range(0, 3) == 0) start_state = 8'($urandom);
                a = 2'($urandom);
                model_apply(int'(a), e);
                run_step(a, o);
                n++;
                total++;
                if ({o.st, o.ac, o.rw, o.nx, o.last} !== {e.st, a, e.rw, e.nx, e.last}) begin
                    bad++;
                    $display("FAIL rnd_payload[%0d.%0d]: s=%h a=%0d r=%0d n=%h last=%b, required %h %0d %0d %h %b",
                             run, n, o.st, o.ac, o.rw, o.nx, o.last, e.st, a, e.rw, e.nx, e.last);
                end
                total++;
                if ({o.lat, o.ev_nxt, o.srst, o.srst2} !== {3, e.nx, e.last, 1'b0}) begin
                    bad++;
                    $display("FAIL rnd_timing[%0d.%0d]: lat=%0d eval_nxt=%h srst=%b srst_next=%b, required 3 %h %b 0",
                             run, n, o.lat, o.ev_nxt, o.srst, o.srst2, e.nx, e.last);
                end
                total++;
                if ({cur_state, step_cnt, ep_cnt, done} !== {e.cur_after, 8'(m_step), 16'(m_ep), m_done}) begin
                    bad++;
                    $display("FAIL rnd_counters[%0d.%0d]: cur=%h step=%0d ep=%0d done=%b, required %h %0d %0d %b",
                             run, n, cur_state, step_cnt, ep_cnt, done, e.cur_after, m_step, m_ep, m_done);
                end
                total++;
                if (o.epr !== e.epr) begin
                    bad++;
                    $display("FAIL rnd_epr[%0d.%0d]: got %0d, required %0d", run, n, o.epr, e.epr);
                end
            end
            total++;
            if ({done, busy} !== 2'b10) begin
                bad++;
                $display("FAIL rnd_end[%0d]: done=%b busy=%b, required 1 0", run, done, busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_state = '0;
        act_valid = 1'b0; act = '0; tr_ready = 1'b0;
        test_reset();
        test_first_step();
        test_clamp_and_ignore();
        test_hold();
        test_rst_mid();
        test_goal();
        test_ep_reward();
        test_random_runs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
